op_sequencer: RTL and testbench
===============================

// Module: op_sequencer
// PURPOSE
//   Consumer end of the control_unit opcode interface. Samples registered opcode_in
//   (NOP/TXE/RXA/LOG) and runs one operation at a time: a start pulse to the matching
//   datapath unit, a wait for its done, then a one-cycle ack back to the requesting source
//   (DPP, network, NA). The ack makes the source drop its ready line, so the control unit
//   returns to NOP or the next request.
// PARAMETERS
//   TIMEOUT_CYCLES  1024  max WAIT cycles before forced completion; 0 disables timeout
//   HOLDOFF_CYCLES  2     cycles opcode_in is ignored after ack (absorbs stale opcode)
// PORTS
//   clk            in   1  clock; all logic on posedge
//   reset          in   1  reset, synchronous, active-high
//   opcode_in      in   2  00 NOP, 01 TXE, 10 RXA, 11 LOG
//   tx_done_in     in   1  TX engine done pulse
//   rx_done_in     in   1  RX engine done pulse
//   log_done_in    in   1  logger done pulse
//   tx_start_out   out  1  one-cycle start to TX engine (TXE)
//   rx_start_out   out  1  one-cycle start to RX engine (RXA)
//   log_start_out  out  1  one-cycle start to logger (LOG)
//   dpp_ack_out    out  1  one-cycle ack to DPP source (TXE done)
//   nd_ack_out     out  1  one-cycle ack to network source (RXA done)
//   na_ack_out     out  1  one-cycle ack to NA source (LOG done)
//   busy_out       out  1  high in every state except IDLE
//   timeout_out    out  1  one-cycle pulse with the ack when completion came from timeout
//   active_op_out  out  2  latched opcode of the operation in flight; 00 in IDLE
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, active_op 00, timer and holdoff counters 0.
//     Reset mid-operation aborts without an ack. No start pulse is reissued.
//   All outputs are registered.
//   FSM states:
//     IDLE   busy 0. opcode_in != 00 -> latch into active_op -> START. 00 -> stay.
//     START  one cycle. Pulse the start for active_op. Clear timer -> WAIT.
//     WAIT   Only the done matching active_op counts. Other done inputs are ignored.
//            Matching done -> ACK.
//            Else if TIMEOUT_CYCLES != 0 and timer == TIMEOUT_CYCLES-1 -> ACK with the
//            timeout flag set. Else timer++.
//            Done and timeout expiry in the same cycle: done wins; no timeout_out.
//     ACK    one cycle. Pulse the ack for active_op. Pulse timeout_out if flagged.
//            Load holdoff = HOLDOFF_CYCLES -> HOLD, or -> IDLE if HOLDOFF_CYCLES == 0.
//     HOLD   opcode_in ignored. Decrement holdoff. At 1 -> IDLE; clear active_op.
//   Timing, opcode seen in cycle N:
//     start pulse in N+1; done sampled from N+2 onward; done in cycle M -> ack in M+1.
//   Opcode changes during START/WAIT/ACK/HOLD are ignored; active_op is frozen.
//     A new request is taken only from IDLE.
//   Done pulses in IDLE, START, ACK or HOLD are ignored. A late done after reset is
//     ignored.
//   Timer width $clog2(TIMEOUT_CYCLES+1); it never wraps, because it is bounded by the
//     compare.
//   At most one start and one ack output is high in any cycle.
// TESTING
//   TXE, TIMEOUT=1024, HOLDOFF=2:
//     opcode 01 at cycle 0, tx_done 3 cycles after tx_start ->
//     tx_start @1, dpp_ack @5, busy 1..7, idle @8, no rx/log/nd/na activity.
//   RXA, no rx_done, TIMEOUT=16 ->
//     rx_start @1, nd_ack and timeout_out together @18, busy drops after holdoff.
//   LOG with log_done in the last WAIT cycle (timer=15, TIMEOUT=16) ->
//     na_ack next cycle, timeout_out stays 0.
//   TXE in WAIT, opcode switches to 10 and rx_done pulses ->
//     ignored. dpp_ack follows tx_done, then rx_start issues once after HOLD.
//   opcode held at 01 for 2 cycles after dpp_ack (stale) ->
//     exactly one tx_start total; opcode 00 afterwards keeps IDLE.
//   Reset asserted in WAIT, tx_done 2 cycles later ->
//     all outputs 0 the cycle after reset, no dpp_ack, state IDLE.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: consumer side of the control_unit opcode interface.
// Takes one opcode at a time from IDLE, pulses the matching datapath start,
// waits for that unit's done (or a timeout), acks the requesting source, then
// ignores opcode_in for a short holdoff so a stale opcode is not re-taken.
// Every output is a flop loaded from the next-state decode.
module op_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] opcode_in,
    input  logic       tx_done_in,
    input  logic       rx_done_in,
    input  logic       log_done_in,
    output logic       tx_start_out,
    output logic       rx_start_out,
    output logic       log_start_out,
    output logic       dpp_ack_out,
    output logic       nd_ack_out,
    output logic       na_ack_out,
    output logic       busy_out,
    output logic       timeout_out,
    output logic [1:0] active_op_out
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [HW-1:0] H_LOAD = HW'(HOLDOFF_CYCLES);

    localparam logic [1:0] OP_TXE = 2'b01;
    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   timer, timer_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic            to_flag, to_flag_d;
    logic [1:0]      op_d;
    logic            done_match;

    // Only the done line of the unit actually running counts.
    always_comb begin
        done_match = 1'b0;
        case (active_op_out)
            OP_TXE:  done_match = tx_done_in;
            OP_RXA:  done_match = rx_done_in;
            OP_LOG:  done_match = log_done_in;
            default: done_match = 1'b0;
        endcase
    end

    // Next-state, counters and latched opcode.
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        hold_d    = hold_cnt;
        to_flag_d = to_flag;
        op_d      = active_op_out;
        case (state)
            S_IDLE: begin
                if (opcode_in != 2'b00) begin
                    op_d    = opcode_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                timer_d   = '0;
                to_flag_d = 1'b0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (done_match) begin
                    state_d = S_ACK;
                end else if (TIMEOUT_CYCLES != 0 && timer == T_LAST) begin
                    to_flag_d = 1'b1;
                    state_d   = S_ACK;
                end else if (TIMEOUT_CYCLES != 0) begin
                    timer_d = timer + 1'b1;
                end
            end
            S_ACK: begin
                if (HOLDOFF_CYCLES == 0) begin
                    op_d    = 2'b00;
                    state_d = S_IDLE;
                end else begin
                    hold_d  = H_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                hold_d = hold_cnt - 1'b1;
                if (hold_cnt == HW'(1)) begin
                    op_d    = 2'b00;
                    state_d = S_IDLE;
                end
            end
            default: begin
                op_d    = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State plus registered outputs decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            hold_cnt      <= '0;
            to_flag       <= 1'b0;
            active_op_out <= 2'b00;
            tx_start_out  <= 1'b0;
            rx_start_out  <= 1'b0;
            log_start_out <= 1'b0;
            dpp_ack_out   <= 1'b0;
            nd_ack_out    <= 1'b0;
            na_ack_out    <= 1'b0;
            busy_out      <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            hold_cnt      <= hold_d;
            to_flag       <= to_flag_d;
            active_op_out <= op_d;
            tx_start_out  <= (state_d == S_START) && (op_d == OP_TXE);
            rx_start_out  <= (state_d == S_START) && (op_d == OP_RXA);
            log_start_out <= (state_d == S_START) && (op_d == OP_LOG);
            dpp_ack_out   <= (state_d == S_ACK) && (op_d == OP_TXE);
            nd_ack_out    <= (state_d == S_ACK) && (op_d == OP_RXA);
            na_ack_out    <= (state_d == S_ACK) && (op_d == OP_LOG);
            busy_out      <= (state_d != S_IDLE);
            timeout_out   <= (state_d == S_ACK) && to_flag_d;
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer. A full stimulus trace (directed scenarios followed by
// random traffic) is built up front; a timeline model then predicts every output
// for every cycle from the operation rules, and the run compares cycle by cycle.
module tb_op_sequencer;

    localparam int T = 16;
    localparam int H = 2;
    localparam int N = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] opcode_in;
    logic       tx_done_in, rx_done_in, log_done_in;
    logic       tx_start_out, rx_start_out, log_start_out;
    logic       dpp_ack_out, nd_ack_out, na_ack_out;
    logic       busy_out, timeout_out;
    logic [1:0] active_op_out;

    op_sequencer #(.TIMEOUT_CYCLES(T), .HOLDOFF_CYCLES(H)) dut (
        .clk(clk), .reset(reset), .opcode_in(opcode_in),
        .tx_done_in(tx_done_in), .rx_done_in(rx_done_in), .log_done_in(log_done_in),
        .tx_start_out(tx_start_out), .rx_start_out(rx_start_out), .log_start_out(log_start_out),
        .dpp_ack_out(dpp_ack_out), .nd_ack_out(nd_ack_out), .na_ack_out(na_ack_out),
        .busy_out(busy_out), .timeout_out(timeout_out), .active_op_out(active_op_out)
    );

    always #5 clk = ~clk;

    // Stimulus per cycle.
    logic [1:0] op_a  [N];
    logic       rst_a [N];
    logic       txd_a [N];
    logic       rxd_a [N];
    logic       lgd_a [N];
    // Expected outputs: {tx_s, rx_s, log_s, dpp, nd, na, busy, timeout, active[1:0]}
    logic [9:0] exp_a [N];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic done_for(input logic [1:0] op, input int k);
        case (op)
            2'b01:   return txd_a[k];
            2'b10:   return rxd_a[k];
            default: return lgd_a[k];
        endcase
    endfunction

    // Directed scenarios up to cycle 110, then random traffic.
    task automatic build_stimulus();
        for (int c = 0; c < N; c++) begin
            op_a[c] = 2'b00; rst_a[c] = 1'b0;
            txd_a[c] = 1'b0; rxd_a[c] = 1'b0; lgd_a[c] = 1'b0;
        end
        rst_a[0] = 1'b1; rst_a[1] = 1'b1;
        // TXE, done 3 cycles after start, opcode held (stale) through the holdoff.
        for (int c = 2; c <= 9; c++) op_a[c] = 2'b01;
        txd_a[6] = 1'b1;
        // RXA with no done: timeout path.
        op_a[20] = 2'b10;
        // LOG with done in the last WAIT cycle, plus a foreign done mid-wait.
        op_a[45] = 2'b11;
        lgd_a[62] = 1'b1;
        txd_a[50] = 1'b1;
        // TXE, opcode switches to RXA mid-wait with a stray rx_done.
        op_a[70] = 2'b01;
        for (int c = 73; c <= 81; c++) op_a[c] = 2'b10;
        rxd_a[74] = 1'b1;
        txd_a[76] = 1'b1;
        rxd_a[85] = 1'b1;
        // Reset in WAIT, late tx_done afterwards.
        op_a[95] = 2'b01;
        rst_a[99] = 1'b1;
        txd_a[101] = 1'b1;
        for (int c = 110; c < N; c++) begin
            op_a[c]  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            txd_a[c] = ($urandom_range(0, 7) == 0);
            rxd_a[c] = ($urandom_range(0, 7) == 0);
            lgd_a[c] = ($urandom_range(0, 7) == 0);
            rst_a[c] = ($urandom_range(0, 199) == 0);
        end
    endtask

    // Timeline model: an operation accepted from cycle s starts at s+1, looks
    // for its done in s+2..s+1+T, acks the cycle after, holds H cycles, and the
    // machine samples again the cycle after that. A reset in cycle r blanks
    // every cycle after r and the machine samples again at r+1.
    task automatic build_expected();
        int pos, s, m, a, last, r, stop;
        logic [1:0] op;
        logic to;
        for (int c = 0; c < N; c++) exp_a[c] = '0;
        pos = 0;
        while (pos < N) begin
            if (rst_a[pos] || op_a[pos] == 2'b00) begin
                pos++;
                continue;
            end
            s  = pos;
            op = op_a[pos];
            m  = -1;
            to = 1'b0;
            for (int k = s + 2; k <= s + 1 + T; k++)
                if (m < 0 && k < N && done_for(op, k)) m = k;
            if (m < 0) begin
                m  = s + 1 + T;
                to = 1'b1;
            end
            a    = m + 1;
            last = a + H;
            r    = -1;
            for (int k = s; k <= last; k++)
                if (r < 0 && k < N && rst_a[k]) r = k;
            stop = (r >= 0) ? r : last;
            for (int k = s + 1; k <= stop && k < N; k++) begin
                exp_a[k][3]   = 1'b1;
                exp_a[k][1:0] = op;
                if (k == s + 1) exp_a[k][9 - (int'(op) - 1)] = 1'b1;
                if (k == a) begin
                    exp_a[k][6 - (int'(op) - 1)] = 1'b1;
                    exp_a[k][2] = to;
                end
            end
            pos = (r >= 0) ? r : last + 1;
        end
    endtask

    initial begin
        build_stimulus();
        build_expected();
        reset = 1'b1; opcode_in = 2'b00;
        tx_done_in = 1'b0; rx_done_in = 1'b0; log_done_in = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            reset       = rst_a[c];
            opcode_in   = op_a[c];
            tx_done_in  = txd_a[c];
            rx_done_in  = rxd_a[c];
            log_done_in = lgd_a[c];
            @(negedge clk);
            if (c >= 1)
                chk($sformatf("cyc%0d", c),
                    {tx_start_out, rx_start_out, log_start_out,
                     dpp_ack_out, nd_ack_out, na_ack_out,
                     busy_out, timeout_out, active_op_out},
                    exp_a[c]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
